// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU, with a one-entry response register and a flag register.
// Latency: the result is registered at the accepting edge (1 cycle); one operation per cycle while the consumer drains.
// Backpressure: no grant while a held response is not being taken (resp_ready=0) or while flush is asserted.
module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [3:0]  req0_opcode,
  input  logic [15:0] req0_rs,
  input  logic [15:0] req0_rt,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [3:0]  req1_opcode,
  input  logic [15:0] req1_rs,
  input  logic [15:0] req1_rt,
  output logic        req1_ready,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_rs,
  output logic [15:0] alu_rt,
  output logic [2:0]  alu_flags_in,
  input  logic [15:0] alu_rd,
  input  logic [2:0]  alu_flag_out,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [15:0] resp_rd,
  input  logic        resp_ready,
  input  logic        flush,
  output logic [2:0]  flags
);

  // Set when requester 1 was the most recent accepted grant; requester 0 wins the next tie.
  logic last_gnt1;
  logic slot_free;
  logic grant_ok;
  logic tie_to_0;
  logic grant0;
  logic grant1;
  logic accept;

  // Arbitration: a grant needs a free result slot, no flush, and reset released.
  always_comb begin
    slot_free = !resp_valid || resp_ready;
    grant_ok  = slot_free && !flush && rst_n;
    tie_to_0  = !RR_EN || last_gnt1;
    grant0    = grant_ok && req0_valid && (!req1_valid || tie_to_0);
    grant1    = grant_ok && req1_valid && !grant0;
    accept    = grant0 || grant1;
  end

  assign req0_ready   = grant0;
  assign req1_ready   = grant1;
  assign alu_flags_in = flags;

  // Operand mux to the ALU; requester 0 is presented whenever requester 1 is not granted.
  always_comb begin
    alu_opcode = req0_opcode;
    alu_rs     = req0_rs;
    alu_rt     = req0_rt;
    if (grant1) begin
      alu_opcode = req1_opcode;
      alu_rs     = req1_rs;
      alu_rt     = req1_rt;
    end
  end

  // Response register: flush kills, acceptance loads, a drain without refill empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_rd    <= 16'h0000;
    end else begin
      if (flush) begin
        resp_valid <= 1'b0;
      end else if (accept) begin
        resp_valid <= 1'b1;
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
      end
      if (accept) begin
        resp_id <= grant1;
        resp_rd <= alu_rd;
      end
    end
  end

  // Architectural flags follow requester 0 only; flush never rolls them back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 3'b000;
    end else if (grant0) begin
      flags <= alu_flag_out;
    end
  end

  // Round-robin pointer moves only on an accepted grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt1 <= 1'b1;
    end else if (accept) begin
      last_gnt1 <= grant1;
    end
  end

endmodule
